cu_ode_sequencer: RTL and testbench

//  Parametrised control unit for fixed-step ODE solvers (Euler, Heun, RK4) driving attractor datapaths.

---
 rtl/cu_pkg.sv | 12 +
 rtl/cu_lat_timer.sv | 25 ++
 rtl/cu_ode_sequencer.sv | 160 ++++++++++++++++
 tb/tb_cu_ode_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared constants for the ODE solver control unit: FSM state encoding and run modes.
package cu_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] UPDATE = 2'd3;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_FREE   = 1'b1;

endpackage

// File: rtl/cu_lat_timer.sv
// Loadable 8-bit down-counter with a zero flag; times the datapath latency of one stage.
module cu_lat_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] loadVal_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= loadVal_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cu_ode_sequencer.sv
// Control unit for fixed-step ODE solvers: issues STAGES sub-stages per step, then loads the
// state registers, with single-step/free-run modes, a step budget and graceful stop.
module cu_ode_sequencer
  import cu_pkg::*;
#(
  parameter int  STAGES    = 4,
  parameter int  STAGE_LAT = 2,
  parameter int  CNT_W     = 16,
  localparam int SW        = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] n_steps_i,
  input  logic             stop_i,
  input  logic             init_i,
  output logic             sel_o,
  output logic [SW-1:0]    stage_o,
  output logic             stage_en_o,
  output logic             en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] step_cnt_o
);

  localparam logic [SW-1:0] LAST_STAGE = SW'(STAGES - 1);
  // ISSUE is the first latency cycle and WAIT ends on the zero cycle, hence the -2.
  localparam logic [7:0]    LAT_LOAD   = (STAGE_LAT > 1) ? 8'(STAGE_LAT - 2) : 8'd0;

  logic [1:0]       state_q, state_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [CNT_W-1:0] stepCnt_q, stepCnt_d;
  logic [CNT_W-1:0] runCnt_q, runCnt_d;
  logic [CNT_W-1:0] nSteps_q, nSteps_d;
  logic             mode_q, mode_d;
  logic             stop_q, stop_d;
  logic             sel_q, sel_d;
  logic             done_q, done_d;
  logic             timerLoad, timerDec, timerZero;
  logic             endStage, runEnds;
  logic [CNT_W-1:0] runCntInc;

  cu_lat_timer u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (timerLoad),
    .loadVal_i (LAT_LOAD),
    .dec_i     (timerDec),
    .zero_o    (timerZero)
  );

  assign runCntInc = runCnt_q + CNT_W'(1);
  assign runEnds   = (mode_q != MODE_FREE) || stop_q || stop_i ||
                     ((nSteps_q != '0) && (runCntInc == nSteps_q));

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    stepCnt_d = stepCnt_q;
    runCnt_d  = runCnt_q;
    nSteps_d  = nSteps_q;
    mode_d    = mode_q;
    stop_d    = stop_q;
    sel_d     = sel_q;
    done_d    = 1'b0;
    timerLoad = 1'b0;
    timerDec  = 1'b0;
    endStage  = 1'b0;
    case (state_q)
      IDLE: begin
        if (init_i) begin
          sel_d     = 1'b0;
          stepCnt_d = '0;
        end
        if (start_i) begin
          mode_d   = mode_i;
          nSteps_d = n_steps_i;
          runCnt_d = '0;
          stop_d   = 1'b0;
          stage_d  = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        stop_d = stop_q | stop_i;
        if (STAGE_LAT == 1) begin
          endStage = 1'b1;
        end else begin
          timerLoad = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        stop_d = stop_q | stop_i;
        if (timerZero) begin
          endStage = 1'b1;
        end else begin
          timerDec = 1'b1;
        end
      end
      UPDATE: begin
        stepCnt_d = stepCnt_q + CNT_W'(1);
        runCnt_d  = runCntInc;
        sel_d     = 1'b1;
        // A pending stop always ends the run here, so the latch can be dropped either way.
        stop_d    = 1'b0;
        if (runEnds) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          stage_d = '0;
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (endStage) begin
      if (stage_q == LAST_STAGE) begin
        state_d = UPDATE;
      end else begin
        stage_d = stage_q + SW'(1);
        state_d = ISSUE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      stage_q   <= '0;
      stepCnt_q <= '0;
      runCnt_q  <= '0;
      nSteps_q  <= '0;
      mode_q    <= MODE_SINGLE;
      stop_q    <= 1'b0;
      sel_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      stepCnt_q <= stepCnt_d;
      runCnt_q  <= runCnt_d;
      nSteps_q  <= nSteps_d;
      mode_q    <= mode_d;
      stop_q    <= stop_d;
      sel_q     <= sel_d;
      done_q    <= done_d;
    end
  end

  assign sel_o      = sel_q;
  assign stage_o    = stage_q;
  assign stage_en_o = (state_q == ISSUE);
  assign en_o       = (state_q == UPDATE);
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign step_cnt_o = stepCnt_q;

endmodule

// File: tb/tb_cu_ode_sequencer.sv
// Three sequencer configurations driven by one shared stimulus stream and checked every cycle
// against a step-schedule reference model, plus targeted timing checks on the RK4 instance.
module tb_cu_ode_sequencer;

  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, mode, stop, init;
  logic [15:0] nSteps;

  logic        sel0, stageEn0, en0, busy0, done0;
  logic [1:0]  stage0;
  logic [15:0] stepCnt0;
  logic        sel1, stageEn1, en1, busy1, done1;
  logic [0:0]  stage1;
  logic [2:0]  stepCnt1;
  logic        sel2, stageEn2, en2, busy2, done2;
  logic [1:0]  stage2;
  logic [3:0]  stepCnt2;

  cu_ode_sequencer #(.STAGES(4), .STAGE_LAT(2), .CNT_W(16)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .n_steps_i(nSteps),
    .stop_i(stop), .init_i(init), .sel_o(sel0), .stage_o(stage0), .stage_en_o(stageEn0),
    .en_o(en0), .busy_o(busy0), .done_o(done0), .step_cnt_o(stepCnt0)
  );

  cu_ode_sequencer #(.STAGES(1), .STAGE_LAT(1), .CNT_W(3)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .n_steps_i(nSteps[2:0]),
    .stop_i(stop), .init_i(init), .sel_o(sel1), .stage_o(stage1), .stage_en_o(stageEn1),
    .en_o(en1), .busy_o(busy1), .done_o(done1), .step_cnt_o(stepCnt1)
  );

  cu_ode_sequencer #(.STAGES(3), .STAGE_LAT(4), .CNT_W(4)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .n_steps_i(nSteps[3:0]),
    .stop_i(stop), .init_i(init), .sel_o(sel2), .stage_o(stage2), .stage_en_o(stageEn2),
    .en_o(en2), .busy_o(busy2), .done_o(done2), .step_cnt_o(stepCnt2)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: a run is a timeline of steps of STAGES*STAGE_LAT+1 cycles each.
  bit mActive[ND];
  bit mSel[ND];
  bit mDone[ND];
  bit mStopF[ND];
  int mRel[ND];
  int mSteps[ND];
  int mLimit[ND];
  int mStepCnt[ND];
  int mStageHold[ND];

  // Per-cycle traces of the RK4 instance (and the Euler instance) relative to a marked start.
  logic [63:0] seMask, enMask, doneMask, busyMask, se1Mask, en1Mask;
  int          relCyc = 0;

  function automatic int stagesOf(input int d);
    case (d)
      0:       return 4;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int latOf(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int widthOf(input int d);
    case (d)
      0:       return 16;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, observed, expected);
    end
  endtask

  task automatic advanceModel();
    for (int d = 0; d < ND; d++) begin
      int p, pos, mask;
      p    = stagesOf(d) * latOf(d) + 1;
      mask = (1 << widthOf(d)) - 1;
      if (rst) begin
        mActive[d]    = 1'b0;
        mSel[d]       = 1'b0;
        mDone[d]      = 1'b0;
        mStopF[d]     = 1'b0;
        mStepCnt[d]   = 0;
        mStageHold[d] = 0;
      end else begin
        mDone[d] = 1'b0;
        if (!mActive[d]) begin
          if (init) begin
            mSel[d]     = 1'b0;
            mStepCnt[d] = 0;
          end
          if (start) begin
            mActive[d] = 1'b1;
            mRel[d]    = 1;
            mSteps[d]  = 0;
            mStopF[d]  = 1'b0;
            mLimit[d]  = mode ? (int'(nSteps) & mask) : 1;
          end
        end else begin
          pos = (mRel[d] - 1) % p;
          if (stop) mStopF[d] = 1'b1;
          if (pos == p - 1) begin
            mStepCnt[d] = (mStepCnt[d] + 1) & mask;
            mSel[d]     = 1'b1;
            mSteps[d]++;
            if (mStopF[d] || (mLimit[d] != 0 && mSteps[d] == mLimit[d])) begin
              mActive[d]    = 1'b0;
              mDone[d]      = 1'b1;
              mStageHold[d] = stagesOf(d) - 1;
            end else begin
              mRel[d]++;
            end
          end else begin
            mRel[d]++;
          end
        end
      end
    end
  endtask

  task automatic checkAll();
    for (int d = 0; d < ND; d++) begin
      logic [63:0] oSel, oStage, oStageEn, oEn, oBusy, oDone, oCnt;
      logic [63:0] eStage, eStageEn, eEn, eBusy;
      int s, l, p, pos;
      s = stagesOf(d);
      l = latOf(d);
      p = s * l + 1;
      case (d)
        0: begin
          oSel = 64'(sel0); oStage = 64'(stage0); oStageEn = 64'(stageEn0);
          oEn = 64'(en0); oBusy = 64'(busy0); oDone = 64'(done0); oCnt = 64'(stepCnt0);
        end
        1: begin
          oSel = 64'(sel1); oStage = 64'(stage1); oStageEn = 64'(stageEn1);
          oEn = 64'(en1); oBusy = 64'(busy1); oDone = 64'(done1); oCnt = 64'(stepCnt1);
        end
        default: begin
          oSel = 64'(sel2); oStage = 64'(stage2); oStageEn = 64'(stageEn2);
          oEn = 64'(en2); oBusy = 64'(busy2); oDone = 64'(done2); oCnt = 64'(stepCnt2);
        end
      endcase
      if (mActive[d]) begin
        pos      = (mRel[d] - 1) % p;
        eBusy    = 64'd1;
        eStageEn = 64'((pos < s * l) && (pos % l == 0));
        eEn      = 64'(pos == p - 1);
        eStage   = (pos < s * l) ? 64'(pos / l) : 64'(s - 1);
      end else begin
        eBusy    = 64'd0;
        eStageEn = 64'd0;
        eEn      = 64'd0;
        eStage   = 64'(mStageHold[d]);
      end
      checkOutput($sformatf("dut%0d busy_o", d), oBusy, eBusy);
      checkOutput($sformatf("dut%0d stage_en_o", d), oStageEn, eStageEn);
      checkOutput($sformatf("dut%0d en_o", d), oEn, eEn);
      checkOutput($sformatf("dut%0d stage_o", d), oStage, eStage);
      checkOutput($sformatf("dut%0d done_o", d), oDone, 64'(mDone[d]));
      checkOutput($sformatf("dut%0d sel_o", d), oSel, 64'(mSel[d]));
      checkOutput($sformatf("dut%0d step_cnt_o", d), oCnt, 64'(mStepCnt[d]));
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic m, input logic [15:0] n,
                               input logic st, input logic in);
    rst    = r;
    start  = s;
    mode   = m;
    nSteps = n;
    stop   = st;
    init   = in;
    advanceModel();
    @(negedge clk);
    cyc++;
    checkAll();
    if (relCyc < 64) begin
      seMask[relCyc]   = stageEn0;
      enMask[relCyc]   = en0;
      doneMask[relCyc] = done0;
      busyMask[relCyc] = busy0;
      se1Mask[relCyc]  = stageEn1;
      en1Mask[relCyc]  = en1;
    end
    relCyc++;
  endtask

  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic markStart();
    relCyc   = 1;
    seMask   = '0;
    enMask   = '0;
    doneMask = '0;
    busyMask = '0;
    se1Mask  = '0;
    en1Mask  = '0;
  endtask

  initial begin
    markStart();

    // Reset state.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    checkOutput("reset outputs", 64'({sel0, stage0, stageEn0, en0, busy0, done0, stepCnt0}), 64'd0);
    runIdle(1);

    // Single RK4 step: stage issues at 1,3,5,7, state load at 9, done at 10.
    markStart();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
    runIdle(11);
    checkOutput("single stage_en cycles", seMask, 64'hAA);
    checkOutput("single en cycle", enMask, 64'h200);
    checkOutput("single done cycle", doneMask, 64'h400);
    checkOutput("single step_cnt", 64'(stepCnt0), 64'd1);
    checkOutput("single sel", 64'(sel0), 64'd1);

    // Free-run with a budget of three steps.
    markStart();
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd3, 1'b0, 1'b0);
    runIdle(29);
    checkOutput("budget en cycles", enMask, 64'h0804_0200);
    checkOutput("budget done cycle", doneMask, 64'h1000_0000);
    checkOutput("budget busy cycles", 64'($countones(busyMask)), 64'd27);

    // Unbounded free-run started together with init, stopped inside step 5.
    markStart();
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd0, 1'b0, 1'b1);
    runIdle(40);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0);
    runIdle(8);
    checkOutput("stop en cycles", enMask, 64'h0000_2010_0804_0200);
    checkOutput("stop done cycle", doneMask, 64'h0000_4000_0000_0000);
    checkOutput("stop step_cnt", 64'(stepCnt0), 64'd5);

    // init in IDLE clears; init while busy is ignored.
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
    checkOutput("init idle sel", 64'(sel0), 64'd0);
    checkOutput("init idle step_cnt", 64'(stepCnt0), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
    runIdle(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
    runIdle(8);
    checkOutput("init busy step_cnt", 64'(stepCnt0), 64'd1);
    checkOutput("init busy sel", 64'(sel0), 64'd1);

    // Reset while waiting on the datapath.
    runIdle(30);
    markStart();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
    runIdle(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    checkOutput("mid-step reset outputs",
                64'({sel0, stage0, stageEn0, en0, busy0, done0, stepCnt0}), 64'd0);
    runIdle(10);
    checkOutput("mid-step reset en", enMask, 64'd0);
    checkOutput("mid-step reset done", doneMask, 64'd0);

    // Euler free-run alternates issue/load every cycle; a start while busy is ignored.
    markStart();
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd0, 1'b0, 1'b0);
    runIdle(3);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
    runIdle(3);
    checkOutput("euler stage_en cycles", se1Mask, 64'hAA);
    checkOutput("euler en cycles", en1Mask, 64'h154);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0);
    runIdle(40);

    // Randomized traffic, including starts/inits while busy, stops and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(1'($urandom_range(0, 199) == 0),
                    1'($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 1)),
                    16'($urandom_range(0, 20)),
                    1'($urandom_range(0, 39) == 0),
                    1'($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
